key_entry_buf: RTL and testbench

KEY_ENTRY_BUF -- requirements
Module: key_entry_buf

---
 rtl/pass_pkg.sv | 35 +++
 rtl/entry_timer.sv | 38 +++
 rtl/key_entry_buf.sv | 132 +++++++++++++
 tb/tb_key_entry_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pass_pkg.sv
// Shared key codes, blank patterns and FSM encoding for the password entry path.
package pass_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned PASS_W   = 16;
  localparam int unsigned CNT_W    = 3;

  localparam logic [NIBBLE_W-1:0] KEY_BKSP     = 4'hA;
  localparam logic [NIBBLE_W-1:0] KEY_ENTER    = 4'hB;
  localparam logic [NIBBLE_W-1:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'hF;
  localparam logic [PASS_W-1:0]   PASS_BLANK   = 16'hFFFF;
  localparam logic [CNT_W-1:0]    CNT_FULL     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic is_digit(input logic [NIBBLE_W-1:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

  // State is a pure function of the digit count.
  function automatic state_e state_for_cnt(input logic [CNT_W-1:0] cnt);
    if (cnt == '0) begin
      return ST_IDLE;
    end else if (cnt >= CNT_FULL) begin
      return ST_FULL;
    end
    return ST_ENTRY;
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle counter for an unfinished entry; expire_c_o flags the final count while running.
module entry_timer
  import pass_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_c_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire_c_o = run_i && (count_q == LAST);

  // Expiry also restarts the count so it never wraps past LAST.
  always_comb begin
    count_d = count_q + CW'(1);
    if (clear_i || !run_i || expire_c_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/key_entry_buf.sv
// Keypad password entry buffer: shifts BCD digits in, backspace/enter/clear handling.
// Optional idle auto-clear is built when ENTRY_TIMEOUT_EN is defined.
module key_entry_buf
  import pass_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned DIGITS         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_val,
  input  logic              key_en,
  input  logic              clear_req,
  output logic [PASS_W-1:0] passvalue,
  output logic [PASS_W-1:0] password,
  output logic              entry_done,
  output logic              entry_err,
  output logic [CNT_W-1:0]  digit_cnt,
  output logic              timeout
);

  if (DIGITS != 4) begin : g_bad_digits
    $error("key_entry_buf: only DIGITS == 4 is supported");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("key_entry_buf: TIMEOUT_CYCLES must be at least 2");
  end

  state_e            state_q, state_d;
  logic [PASS_W-1:0] pv_q, pv_d;
  logic [PASS_W-1:0] pw_q, pw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              key_acc_c;
  logic              expire_c;

`ifdef ENTRY_TIMEOUT_EN
  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_entry_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_req | key_acc_c),
    .run_i     (state_q != ST_IDLE),
    .expire_c_o(expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  // Next-state: clear_req beats keys, an accepted key beats timer expiry.
  always_comb begin
    state_d   = state_q;
    pv_d      = pv_q;
    pw_d      = pw_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    key_acc_c = 1'b0;

    if (clear_req) begin
      pv_d    = PASS_BLANK;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (key_en) begin
      if (is_digit(key_val)) begin
        if (state_q != ST_FULL) begin
          pv_d      = {pv_q[PASS_W-NIBBLE_W-1:0], key_val};
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = state_for_cnt(cnt_d);
          key_acc_c = 1'b1;
        end
      end else if (key_val == KEY_BKSP) begin
        if (state_q != ST_IDLE) begin
          pv_d      = {BLANK_NIBBLE, pv_q[PASS_W-1:NIBBLE_W]};
          cnt_d     = cnt_q - CNT_W'(1);
          state_d   = state_for_cnt(cnt_d);
          key_acc_c = 1'b1;
        end
      end else if (key_val == KEY_ENTER) begin
        if (state_q == ST_FULL) begin
          pw_d      = pv_q;
          done_d    = 1'b1;
          pv_d      = PASS_BLANK;
          cnt_d     = '0;
          state_d   = ST_IDLE;
          key_acc_c = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (!clear_req && !key_acc_c && expire_c) begin
      pv_d    = PASS_BLANK;
      cnt_d   = '0;
      state_d = ST_IDLE;
      tmo_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pv_q    <= PASS_BLANK;
      pw_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= pv_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign passvalue  = pv_q;
  assign password   = pw_q;
  assign digit_cnt  = cnt_q;
  assign entry_done = done_q;
  assign entry_err  = err_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_key_entry_buf.sv
// Scoreboard bench for key_entry_buf: driver queues per-cycle expectations, monitor checks them.
module tb_key_entry_buf;

  logic        clk;
  logic        rst;
  logic [3:0]  key_val;
  logic        key_en;
  logic        clear_req;
  logic [15:0] passvalue;
  logic [15:0] password;
  logic        entry_done;
  logic        entry_err;
  logic [2:0]  digit_cnt;
  logic        timeout;

  key_entry_buf #(
    .TIMEOUT_CYCLES(16),
    .DIGITS        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_val   (key_val),
    .key_en    (key_en),
    .clear_req (clear_req),
    .passvalue (passvalue),
    .password  (password),
    .entry_done(entry_done),
    .entry_err (entry_err),
    .digit_cnt (digit_cnt),
    .timeout   (timeout)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] pv;
    logic [2:0]  cnt;
    logic [15:0] pw;
    logic        d;
    logic        e;
    logic        t;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int unsigned n_vec;
  int unsigned n_bad;
  logic [15:0] pw_exp;
  bit          drive_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the DUT against the expectation queued for this cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      x = sb_q.pop_front();
      n_vec = n_vec + 1;
      if (x.cyc != cyc) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", x.nm, x.cyc, cyc);
      end else if (passvalue !== x.pv || digit_cnt !== x.cnt || password !== x.pw ||
                   entry_done !== x.d || entry_err !== x.e || timeout !== x.t) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got pv=%h cnt=%0d pw=%h done=%b err=%b tmo=%b, want pv=%h cnt=%0d pw=%h done=%b err=%b tmo=%b",
                 x.nm, passvalue, digit_cnt, password, entry_done, entry_err, timeout,
                 x.pv, x.cnt, x.pw, x.d, x.e, x.t);
      end
    end
  end

  task automatic step(input logic en, input logic [3:0] kv, input logic clr, input logic r,
                      input logic [15:0] pv, input logic [2:0] cnt,
                      input logic d, input logic e, input logic t, input string nm);
    exp_t x;
    @(negedge clk);
    key_en    = en;
    key_val   = kv;
    clear_req = clr;
    rst       = r;
    x.cyc = cyc + 1;
    x.pv  = pv;
    x.cnt = cnt;
    x.pw  = pw_exp;
    x.d   = d;
    x.e   = e;
    x.t   = t;
    x.nm  = nm;
    sb_q.push_back(x);
  endtask

  task automatic key(input logic [3:0] kv, input logic [15:0] pv, input logic [2:0] cnt, input string nm);
    step(1'b1, kv, 1'b0, 1'b0, pv, cnt, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic idle(input int n, input logic [15:0] pv, input logic [2:0] cnt, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0, pv, cnt, 1'b0, 1'b0, 1'b0, nm);
    end
  endtask

  task automatic clr(input string nm);
    step(1'b0, 4'h0, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0; drive_done = 1'b0;
    pw_exp = 16'h0000;
    rst = 1'b1; key_en = 1'b0; key_val = 4'h0; clear_req = 1'b0;

    step(1'b0, 4'h0, 1'b0, 1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 4'h0, 1'b0, 1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
    idle(1, 16'hFFFF, 3'd0, "post_reset");

    // Full entry and enter.
    key(4'h1, 16'hFFF1, 3'd1, "d1");
    key(4'h2, 16'hFF12, 3'd2, "d2");
    key(4'h3, 16'hF123, 3'd3, "d3");
    key(4'h4, 16'h1234, 3'd4, "d4");
    pw_exp = 16'h1234;
    step(1'b1, 4'hB, 1'b0, 1'b0, 16'hFFFF, 3'd0, 1'b1, 1'b0, 1'b0, "enter_full");
    idle(1, 16'hFFFF, 3'd0, "done_one_pulse");

    // Short entry then enter.
    key(4'h5, 16'hFFF5, 3'd1, "d5");
    key(4'h6, 16'hFF56, 3'd2, "d6");
    step(1'b1, 4'hB, 1'b0, 1'b0, 16'hFF56, 3'd2, 1'b0, 1'b1, 1'b0, "enter_short");
    idle(1, 16'hFF56, 3'd2, "err_one_pulse");
    clr("clear1");

    // Overfill and backspace to empty.
    key(4'h7, 16'hFFF7, 3'd1, "d7");
    key(4'h8, 16'hFF78, 3'd2, "d8");
    key(4'h9, 16'hF789, 3'd3, "d9");
    key(4'h0, 16'h7890, 3'd4, "d0");
    key(4'h1, 16'h7890, 3'd4, "fifth_ignored");
    key(4'hA, 16'hF789, 3'd3, "bksp1");
    key(4'hA, 16'hFF78, 3'd2, "bksp2");
    key(4'hA, 16'hFFF7, 3'd1, "bksp3");
    key(4'hA, 16'hFFFF, 3'd0, "bksp4");
    key(4'hA, 16'hFFFF, 3'd0, "bksp_idle");
    key(4'hC, 16'hFFFF, 3'd0, "key_c_ignored");

    // clear_req priority and hold.
    step(1'b1, 4'h3, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "clr_drops_key");
    idle(1, 16'hFFFF, 3'd0, "after_clr_key");
    key(4'h1, 16'hFFF1, 3'd1, "d1b");
    key(4'h2, 16'hFF12, 3'd2, "d2b");
    step(1'b1, 4'h5, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "clr_hold1");
    step(1'b1, 4'h6, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "clr_hold2");
    step(1'b1, 4'hB, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "clr_hold_enter");

    // Reset in the middle of an entry.
    key(4'h1, 16'hFFF1, 3'd1, "d1c");
    key(4'h2, 16'hFF12, 3'd2, "d2c");
    key(4'h3, 16'hF123, 3'd3, "d3c");
    pw_exp = 16'h0000;
    step(1'b0, 4'h0, 1'b0, 1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, "mid_reset");
    idle(2, 16'hFFFF, 3'd0, "after_mid_reset");

`ifdef ENTRY_TIMEOUT_EN
    key(4'h4, 16'hFFF4, 3'd1, "tmo_d4");
    idle(15, 16'hFFF4, 3'd1, "tmo_wait");
    step(1'b0, 4'h0, 1'b0, 1'b0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b1, "tmo_fire");
    idle(1, 16'hFFFF, 3'd0, "tmo_one_pulse");
    key(4'h4, 16'hFFF4, 3'd1, "tmo2_d4");
    idle(15, 16'hFFF4, 3'd1, "tmo2_wait");
    key(4'h5, 16'hFF45, 3'd2, "key_wins_expiry");
    idle(5, 16'hFF45, 3'd2, "tmo2_restarted");
    clr("clear_tmo");
`else
    key(4'h4, 16'hFFF4, 3'd1, "persist_d4");
    idle(1000, 16'hFFF4, 3'd1, "persist");
    clr("clear_persist");
`endif

    idle(2, 16'hFFFF, 3'd0, "final");
    @(negedge clk);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: expectation for cycle %0d never checked", x.nm, x.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    drive_done = 1'b1;
    $finish;
  end

  initial begin
    #200000;
    if (!drive_done) begin
      $display("FAIL watchdog: run did not complete, %0d of %0d vectors bad", n_bad, n_vec);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
